// File: rtl/dac_cond_pkg.sv
// Shared types and constants for the two-channel DAC output conditioner.
package dac_cond_pkg;

  typedef enum logic [1:0] {
    ENV_OFF       = 2'b00,
    ENV_RAMP_UP   = 2'b01,
    ENV_ON        = 2'b10,
    ENV_RAMP_DOWN = 2'b11
  } env_state_e;

  localparam int GAIN_FRAC_BITS = 14;
  localparam int ENV_W          = 15;
  localparam logic [ENV_W-1:0] ENV_ONE = 15'd16384;
  localparam int SAT_CNT_W      = 16;

  function automatic int sat_max(input int dac_w);
    return (1 << (dac_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dac_w);
    return -(1 << (dac_w - 1));
  endfunction

endpackage

// File: rtl/dac_cond_channel.sv
// One conditioner channel: gain/offset/envelope pipeline (4 cycles), soft-start FSM, saturation counter.
// The counter exists only when DAC_COND_SAT_CNT_EN is defined; otherwise sat_cnt_o is tied to 0.
module dac_cond_channel
  import dac_cond_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = 14,
  parameter int IN_DATA_WIDTH  = 16,
  parameter int GAIN_WIDTH     = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic signed [IN_DATA_WIDTH-1:0]  in_i,
  input  logic signed [GAIN_WIDTH-1:0]     gain_i,
  input  logic signed [DAC_DATA_WIDTH-1:0] offset_i,
  input  logic                             enable_i,
  input  logic [ENV_W-1:0]                 ramp_step_i,
  input  logic                             sat_clr_i,
  output logic signed [DAC_DATA_WIDTH-1:0] dat_o,
  output logic [1:0]                       state_o,
  output logic [SAT_CNT_W-1:0]             sat_cnt_o
);

  localparam int PROD1_W = IN_DATA_WIDTH + GAIN_WIDTH;
  localparam int P1_W    = PROD1_W - GAIN_FRAC_BITS + 1;
  localparam int P2_W    = ((P1_W > DAC_DATA_WIDTH) ? P1_W : DAC_DATA_WIDTH) + 1;
  localparam int PROD3_W = P2_W + ENV_W + 1;
  // env never exceeds 1.0, so |p3| <= |p2| and p2's width is enough.
  localparam int P3_W    = P2_W;
  localparam logic signed [P3_W-1:0] SAT_HI = P3_W'(sat_max(DAC_DATA_WIDTH));
  localparam logic signed [P3_W-1:0] SAT_LO = P3_W'(sat_min(DAC_DATA_WIDTH));

  env_state_e             state_q, state_d;
  env_state_e             up_state, dn_state;
  logic [ENV_W-1:0]       env_q, env_d;
  logic [ENV_W:0]         env_sum;
  logic [ENV_W-1:0]       env_up, env_dn;
  logic                   step_zero;

  logic signed [PROD1_W-1:0]        prod1;
  logic signed [P1_W-1:0]           p1_d, p1_q;
  logic signed [DAC_DATA_WIDTH-1:0] off_q;
  logic signed [P2_W-1:0]           p2_d, p2_q;
  logic signed [PROD3_W-1:0]        prod3;
  logic signed [P3_W-1:0]           p3_d, p3_q;
  logic signed [DAC_DATA_WIDTH-1:0] dat_d, dat_q;
  logic                             sat_hi, sat_lo, sat_evt;

  // A zero step means the envelope jumps straight to its end point.
  assign step_zero = (ramp_step_i == '0);
  assign env_sum   = {1'b0, env_q} + {1'b0, ramp_step_i};
  assign env_up    = (step_zero || env_sum >= {1'b0, ENV_ONE}) ? ENV_ONE : env_sum[ENV_W-1:0];
  assign env_dn    = (step_zero || ramp_step_i >= env_q) ? '0 : env_q - ramp_step_i;
  assign up_state  = (env_up == ENV_ONE) ? ENV_ON : ENV_RAMP_UP;
  assign dn_state  = (env_dn == '0) ? ENV_OFF : ENV_RAMP_DOWN;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      ENV_OFF: begin
        if (enable_i) begin
          state_d = up_state;
          env_d   = env_up;
        end
      end
      ENV_RAMP_UP, ENV_RAMP_DOWN: begin
        if (enable_i) begin
          state_d = up_state;
          env_d   = env_up;
        end else begin
          state_d = dn_state;
          env_d   = env_dn;
        end
      end
      ENV_ON: begin
        if (!enable_i) begin
          state_d = dn_state;
          env_d   = env_dn;
        end
      end
      default: begin
        state_d = ENV_OFF;
        env_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ENV_OFF;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Shifts are arithmetic: truncation toward minus infinity, no rounding.
  assign prod1 = PROD1_W'(in_i) * PROD1_W'(gain_i);
  assign p1_d  = P1_W'(prod1 >>> GAIN_FRAC_BITS);
  assign p2_d  = P2_W'(p1_q) + P2_W'(off_q);
  assign prod3 = PROD3_W'(p2_q) * PROD3_W'($signed({1'b0, env_q}));
  assign p3_d  = P3_W'(prod3 >>> GAIN_FRAC_BITS);

  assign sat_hi  = (p3_q > SAT_HI);
  assign sat_lo  = (p3_q < SAT_LO);
  assign sat_evt = sat_hi | sat_lo;

  always_comb begin
    dat_d = p3_q[DAC_DATA_WIDTH-1:0];
    if (sat_hi) begin
      dat_d = SAT_HI[DAC_DATA_WIDTH-1:0];
    end else if (sat_lo) begin
      dat_d = SAT_LO[DAC_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_q  <= '0;
      off_q <= '0;
      p2_q  <= '0;
      p3_q  <= '0;
      dat_q <= '0;
    end else begin
      p1_q  <= p1_d;
      off_q <= offset_i;
      p2_q  <= p2_d;
      p3_q  <= p3_d;
      dat_q <= dat_d;
    end
  end

  assign dat_o   = dat_q;
  assign state_o = state_q;

`ifdef DAC_COND_SAT_CNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr_i) begin
      sat_cnt_d = '0;
    end else if (sat_evt && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`else
  logic cnt_unused;
  assign cnt_unused = sat_clr_i | sat_evt;
  assign sat_cnt_o  = '0;
`endif

endmodule

// File: rtl/dac_output_conditioner.sv
// Two-channel gain/offset/soft-start conditioner feeding the DAC stage; 4-cycle latency, no handshake.
// Saturation counters are built only when DAC_COND_SAT_CNT_EN is defined.
module dac_output_conditioner
  import dac_cond_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = 14,
  parameter int IN_DATA_WIDTH  = 16,
  parameter int GAIN_WIDTH     = 16
) (
  input  logic                             aclk,
  input  logic                             rst,
  input  logic signed [IN_DATA_WIDTH-1:0]  in_a,
  input  logic signed [IN_DATA_WIDTH-1:0]  in_b,
  input  logic signed [GAIN_WIDTH-1:0]     gain_a,
  input  logic signed [GAIN_WIDTH-1:0]     gain_b,
  input  logic signed [DAC_DATA_WIDTH-1:0] offset_a,
  input  logic signed [DAC_DATA_WIDTH-1:0] offset_b,
  input  logic                             enable_a,
  input  logic                             enable_b,
  input  logic [ENV_W-1:0]                 ramp_step,
  input  logic                             sat_clr,
  output logic signed [DAC_DATA_WIDTH-1:0] dat_a_o,
  output logic signed [DAC_DATA_WIDTH-1:0] dat_b_o,
  output logic [1:0]                       state_a,
  output logic [1:0]                       state_b,
  output logic [SAT_CNT_W-1:0]             sat_cnt_a,
  output logic [SAT_CNT_W-1:0]             sat_cnt_b
);

  dac_cond_channel #(
    .DAC_DATA_WIDTH(DAC_DATA_WIDTH),
    .IN_DATA_WIDTH (IN_DATA_WIDTH),
    .GAIN_WIDTH    (GAIN_WIDTH)
  ) u_ch_a (
    .clk_i      (aclk),
    .rst_i      (rst),
    .in_i       (in_a),
    .gain_i     (gain_a),
    .offset_i   (offset_a),
    .enable_i   (enable_a),
    .ramp_step_i(ramp_step),
    .sat_clr_i  (sat_clr),
    .dat_o      (dat_a_o),
    .state_o    (state_a),
    .sat_cnt_o  (sat_cnt_a)
  );

  dac_cond_channel #(
    .DAC_DATA_WIDTH(DAC_DATA_WIDTH),
    .IN_DATA_WIDTH (IN_DATA_WIDTH),
    .GAIN_WIDTH    (GAIN_WIDTH)
  ) u_ch_b (
    .clk_i      (aclk),
    .rst_i      (rst),
    .in_i       (in_b),
    .gain_i     (gain_b),
    .offset_i   (offset_b),
    .enable_i   (enable_b),
    .ramp_step_i(ramp_step),
    .sat_clr_i  (sat_clr),
    .dat_o      (dat_b_o),
    .state_o    (state_b),
    .sat_cnt_o  (sat_cnt_b)
  );

endmodule

// File: tb/tb_dac_output_conditioner.sv
// Bench for dac_output_conditioner: per-cycle reference model plus directed hand-computed checkpoints.
module tb_dac_output_conditioner;

  localparam longint ONE  = 16384;
  localparam int     HMAX = 1024;
`ifdef DAC_COND_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               aclk = 1'b0;
  logic               rst;
  logic signed [15:0] in_a, in_b, gain_a, gain_b;
  logic signed [13:0] offset_a, offset_b;
  logic               enable_a, enable_b, sat_clr;
  logic [14:0]        ramp_step;
  logic signed [13:0] dat_a_o, dat_b_o;
  logic [1:0]         state_a, state_b;
  logic [15:0]        sat_cnt_a, sat_cnt_b;

  int errors = 0;
  int checks = 0;

  dac_output_conditioner dut (
    .aclk(aclk), .rst(rst),
    .in_a(in_a), .in_b(in_b),
    .gain_a(gain_a), .gain_b(gain_b),
    .offset_a(offset_a), .offset_b(offset_b),
    .enable_a(enable_a), .enable_b(enable_b),
    .ramp_step(ramp_step), .sat_clr(sat_clr),
    .dat_a_o(dat_a_o), .dat_b_o(dat_b_o),
    .state_a(state_a), .state_b(state_b),
    .sat_cnt_a(sat_cnt_a), .sat_cnt_b(sat_cnt_b)
  );

  always #4 aclk = ~aclk;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: per-edge history of sampled inputs and envelope values.
  int     e = 0;
  bit     h_rst[HMAX];
  longint h_in[2][HMAX];
  longint h_gain[2][HMAX];
  longint h_off[2][HMAX];
  longint h_env[2][HMAX];
  longint m_env[2];
  longint m_dat[2];
  longint m_state[2];
  longint m_cnt[2];

  function automatic longint ideal(longint x, longint g, longint o, longint env);
    longint p1, p2;
    p1 = (x * g) >>> 14;
    p2 = p1 + o;
    return (p2 * env) >>> 14;
  endfunction

  always @(posedge aclk) begin
    longint stp, p3;
    bit     v_en, rwin, sev;
    e = e + 1;
    if (e < HMAX) begin
      h_rst[e] = rst;
      stp = longint'(ramp_step);
      for (int c = 0; c < 2; c++) begin
        h_in[c][e]   = (c == 0) ? longint'(in_a) : longint'(in_b);
        h_gain[c][e] = (c == 0) ? longint'(gain_a) : longint'(gain_b);
        h_off[c][e]  = (c == 0) ? longint'(offset_a) : longint'(offset_b);
        v_en = (c == 0) ? enable_a : enable_b;
        if (rst) m_env[c] = 0;
        else if (v_en) m_env[c] = (stp == 0 || m_env[c] + stp >= ONE) ? ONE : m_env[c] + stp;
        else m_env[c] = (stp == 0 || m_env[c] <= stp) ? 0 : m_env[c] - stp;
        h_env[c][e] = m_env[c];
        if (rst || m_env[c] == 0) m_state[c] = 0;
        else if (m_env[c] == ONE) m_state[c] = 2;
        else m_state[c] = v_en ? 1 : 3;
        rwin = 1'b1;
        if (e > 3) rwin = h_rst[e] || h_rst[e-1] || h_rst[e-2] || h_rst[e-3];
        sev = 1'b0;
        if (rwin) m_dat[c] = 0;
        else begin
          p3 = ideal(h_in[c][e-3], h_gain[c][e-3], h_off[c][e-3], h_env[c][e-2]);
          sev = (p3 > 8191) || (p3 < -8192);
          m_dat[c] = (p3 > 8191) ? 8191 : (p3 < -8192) ? -8192 : p3;
        end
        if (rst || sat_clr || !CNT_EN) m_cnt[c] = 0;
        else if (sev && m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
      end
    end
  end

  always @(negedge aclk) begin
    if (e > 0 && e < HMAX) begin
      check("dat_a", longint'(dat_a_o), m_dat[0]);
      check("dat_b", longint'(dat_b_o), m_dat[1]);
      check("state_a", longint'(state_a), m_state[0]);
      check("state_b", longint'(state_b), m_state[1]);
      check("sat_cnt_a", longint'(sat_cnt_a), m_cnt[0]);
      check("sat_cnt_b", longint'(sat_cnt_b), m_cnt[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  initial begin
    rst = 1'b1; in_a = '0; in_b = '0; gain_a = '0; gain_b = '0;
    offset_a = '0; offset_b = '0; enable_a = 1'b0; enable_b = 1'b0;
    ramp_step = '0; sat_clr = 1'b0;
    tick(2);
    check("lit_rst_dat_a", longint'(dat_a_o), 0);
    check("lit_rst_state_a", longint'(state_a), 0);
    check("lit_rst_cnt_a", longint'(sat_cnt_a), 0);

    // Full-size step: OFF to ON in one cycle, data after 4.
    rst = 1'b0; enable_a = 1'b1; ramp_step = 15'd16384; gain_a = 16'sd16384; in_a = 16'sd1000;
    enable_b = 1'b1; gain_b = 16'sd8192; in_b = -16'sd1001; offset_b = 14'sd100;
    tick(1);
    check("lit_t1_state_on", longint'(state_a), 2);
    tick(3);
    check("lit_t1_dat", longint'(dat_a_o), 1000);

    // Ramp up at 1024 per cycle with in=8000.
    enable_a = 1'b0; ramp_step = '0;
    tick(1);
    in_a = 16'sd8000; ramp_step = 15'd1024;
    tick(5);
    enable_a = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (k == 3)  check("lit_ramp_dat_500", longint'(dat_a_o), 500);
      if (k == 10) check("lit_ramp_dat_4000", longint'(dat_a_o), 4000);
      if (k == 15) check("lit_ramp_state_up", longint'(state_a), 1);
      if (k == 16) check("lit_ramp_state_on", longint'(state_a), 2);
      if (k == 18) check("lit_ramp_dat_8000", longint'(dat_a_o), 8000);
    end

    // Ramp down at 2048 per cycle.
    ramp_step = 15'd2048;
    tick(8);
    enable_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 1)  check("lit_down_state", longint'(state_a), 3);
      if (k == 3)  check("lit_down_dat_7000", longint'(dat_a_o), 7000);
      if (k == 7)  check("lit_down_state_k7", longint'(state_a), 3);
      if (k == 8)  check("lit_down_state_off", longint'(state_a), 0);
      if (k == 10) check("lit_down_dat_0", longint'(dat_a_o), 0);
    end

    // Saturation both ways and counter clear.
    gain_a = 16'sd32767; in_a = 16'sd32767; ramp_step = '0; enable_a = 1'b1;
    tick(6);
    check("lit_sat_hi", longint'(dat_a_o), 8191);
    check("lit_sat_cnt3", longint'(sat_cnt_a), CNT_EN ? 3 : 0);
    in_a = -16'sd32768;
    tick(4);
    check("lit_sat_lo", longint'(dat_a_o), -8192);
    sat_clr = 1'b1;
    tick(1);
    check("lit_sat_clr", longint'(sat_cnt_a), 0);
    sat_clr = 1'b0;
    tick(1);
    check("lit_sat_after_clr", longint'(sat_cnt_a), CNT_EN ? 1 : 0);

    // Enable removed mid ramp-up at env 6144.
    in_a = 16'sd8000; gain_a = 16'sd16384; enable_a = 1'b0; ramp_step = '0;
    tick(1);
    ramp_step = 15'd2048;
    tick(5);
    enable_a = 1'b1;
    tick(3);
    check("lit_abort_state_up", longint'(state_a), 1);
    enable_a = 1'b0;
    tick(1);
    check("lit_abort_state_down", longint'(state_a), 3);
    tick(1);
    check("lit_abort_peak", longint'(dat_a_o), 3000);
    tick(1);
    check("lit_abort_after", longint'(dat_a_o), 2000);
    check("lit_b_state", longint'(state_b), 2);
    check("lit_b_dat", longint'(dat_b_o), -401);

    // Reset in the middle of a ramp.
    tick(4);
    ramp_step = 15'd1024; enable_a = 1'b1;
    tick(10);
    check("lit_prerst_dat", longint'(dat_a_o), 4000);
    rst = 1'b1;
    tick(1);
    check("lit_rst_mid_dat_a", longint'(dat_a_o), 0);
    check("lit_rst_mid_dat_b", longint'(dat_b_o), 0);
    check("lit_rst_mid_state_a", longint'(state_a), 0);
    check("lit_rst_mid_state_b", longint'(state_b), 0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check("lit_flush_dat_a", longint'(dat_a_o), 0);
    end
    tick(1);
    check("lit_restart_dat_a", longint'(dat_a_o), 1000);
    check("lit_restart_dat_b", longint'(dat_b_o), -51);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_output_conditioner.md
# dac_output_conditioner

Two-channel sample conditioner directly upstream of the Red Pitaya DAC output stage. Each channel applies a programmable gain and offset to the feedback-path sample, multiplies it by a soft-start/soft-stop envelope, and saturates to the DAC word width. The 14-bit signed outputs feed the DAC stage's channel A/B data inputs.

## Interface
Parameters:
- `DAC_DATA_WIDTH`, 14: output word width, signed two's complement.
- `IN_DATA_WIDTH`, 16: input sample width, signed.
- `GAIN_WIDTH`, 16: gain width, signed Q2.14 (16384 = 1.0).

Ports:
- `aclk` in 1: single clock, 125 MHz domain of the DAC stage.
- `rst` in 1: synchronous, active-high reset.
- `in_a`, `in_b` in IN_DATA_WIDTH: signed samples, sampled every cycle.
- `gain_a`, `gain_b` in GAIN_WIDTH: signed Q2.14 gain.
- `offset_a`, `offset_b` in DAC_DATA_WIDTH: signed offset in output LSBs.
- `enable_a`, `enable_b` in 1: level; request ramp up (1) or ramp down (0).
- `ramp_step` in 15: envelope increment per cycle, unsigned; 0 = instantaneous.
- `sat_clr` in 1: clears saturation counters.
- `dat_a_o`, `dat_b_o` out DAC_DATA_WIDTH: conditioned outputs to the DAC stage.
- `state_a`, `state_b` out 2: envelope FSM state (00 OFF, 01 RAMP_UP, 10 ON, 11 RAMP_DOWN).
- `sat_cnt_a`, `sat_cnt_b` out 16: saturation event counters.

## Operation
- Per channel: `p1 = in*gain >>> 14`; `p2 = p1 + offset`; `p3 = p2*env >>> 14`; `out = sat(p3)`.
- All right shifts are arithmetic, with truncation toward −inf. No rounding.
- Intermediate widths are full precision and never wrap:
  - `p1`: 19 bits.
  - `p2`: 20 bits.
  - `env`: 15-bit unsigned, 0..16384.
- Saturation clamps to [−8192, +8191]. Clamping is an event when `p3` lies outside that range.
- Envelope FSM per channel, evaluated every cycle:
  - OFF: `env = 0`. `enable = 1` goes to RAMP_UP. With `ramp_step = 0`, it goes directly to ON with `env = 16384`.
  - RAMP_UP: `env += ramp_step`, clamped at 16384.
    - Reaching 16384 goes to ON.
    - `enable = 0` goes to RAMP_DOWN starting from the current `env`. Removing enable takes priority over the same-cycle increment.
  - ON: `env = 16384`. `enable = 0` goes to RAMP_DOWN. With `ramp_step = 0`, it goes directly to OFF with `env = 0`.
  - RAMP_DOWN: `env −= ramp_step`, clamped at 0.
    - Reaching 0 goes to OFF.
    - `enable = 1` goes to RAMP_UP from the current `env`.
- `ramp_step` changes take effect on the next step.
- `gain` and `offset` are not registered separately. Changes propagate through the pipeline like data.
- Saturation counters increment by 1 per saturated output cycle and hold at 0xFFFF.
  - `sat_clr` zeroes the counter.
  - `sat_clr` wins over a simultaneous increment.

## Timing
- Latency from `in_*` to `dat_*_o` is 4 cycles. Pipeline registers:
  - S1: `p1` (includes input, gain and offset capture).
  - S2: `p2`.
  - S3: `p3`.
  - S4: saturated output.
- `env` is sampled into S3 alongside `p2`. A state change at cycle t affects the output at t+2.
- The output updates every cycle; there is no valid handshake.
- On `rst` (synchronous), in the same cycle edge:
  - All pipeline registers clear to 0.
  - `dat_*_o = 0`.
  - `env = 0`.
  - `state = OFF`.
  - `sat_cnt = 0`.
- A reset during a ramp aborts it. After reset, the FSM restarts from OFF if `enable` is still high.
- Full ramp duration is `ceil(16384/ramp_step)` cycles.

## Configuration
- `DAC_COND_SAT_CNT_EN`:
  - Defined: saturation counters and `sat_clr` logic are built.
  - Undefined: `sat_cnt_a` and `sat_cnt_b` are tied to 0, `sat_clr` is ignored, and no counter logic is inferred.
- Data path and FSM are identical in both builds.

## Structure
- Package `dac_cond_pkg`:
  - Envelope state enum (OFF, RAMP_UP, ON, RAMP_DOWN).
  - `ENV_ONE = 16384`.
  - `GAIN_FRAC_BITS = 14`.
  - Saturation limit constants derived from DAC_DATA_WIDTH.
- Sub-module `dac_cond_channel`: one channel's pipeline, FSM, and counter. The top instantiates it twice and shares `ramp_step` and `sat_clr`.

## Test plan
- Reset, then `enable_a = 1`, `ramp_step = 16384`, `gain_a = 16384`, `offset_a = 0`, `in_a = 1000`. Required: state OFF→ON in 1 cycle, then `dat_a_o = 1000` 4 cycles after the input is stable.
- `ramp_step = 1024`, `in_a = 8000`, unity gain, enable rises. Required: ON reached after 16 cycles, and `dat_a_o` ramps 0, 500, 1000, … up to 8000.
- In ON, drop `enable_a` after 8 steps at `ramp_step = 2048`. Required: RAMP_DOWN, 8 cycles to OFF, and `dat_a_o` returns to 0.
- `gain_a = 32767`, `in_a = 32767`, ON. Required: `dat_a_o = 8191` and `sat_cnt_a` increments every cycle. Then `in_a = −32768`: required `dat_a_o = −8192`. Then `sat_clr` together with saturation: required `sat_cnt_a = 0`. With the macro undefined: counter stays 0.
- Toggle `enable_a` off during RAMP_UP at `env = 6144`. Required: the next cycle is RAMP_DOWN with `env = 6144 − step`, with no overshoot. Channel B stays independent and unaffected.
- Assert `rst` mid-ramp with output nonzero. Required: the next cycle has `dat_*_o = 0`, `state = OFF`, and the pipeline flushed, so 0 is output for the following 4 cycles.
